gigatron_load_arbiter: RTL and testbench

GIGATRON_LOAD_ARBITER -- requirements
Module: gigatron_load_arbiter

---
 rtl/gigatron_load_arbiter.sv | 143 ++++++++++++++
 tb/tb_gigatron_load_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gigatron_load_arbiter.sv
// HPS download arbiter for the Gigatron core: streams RAM images through a
// one-entry holding register behind CPU RAM slots, and packs ROM bytes into words.
module gigatron_load_arbiter #(
  parameter int unsigned RAM_AW = 15,
  parameter int unsigned ROM_AW = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cpu_ce,
  input  logic              cpu_ram_we,
  input  logic [RAM_AW-1:0] cpu_ram_addr,
  input  logic [7:0]        cpu_ram_wdata,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, RAM_LOAD, ROM_LOAD, FLUSH} state_t;

  state_t            state, state_next;
  logic              dl_q, dl_rise, dl_fall;
  logic              hold_valid;
  logic [RAM_AW-1:0] hold_addr;
  logic [7:0]        hold_data;
  logic [7:0]        lo_byte;
  logic              from_rom, from_rom_next;
  logic              cpu_hold_next, load_done_next;
  logic              ram_in_range, rom_in_range, capture, issue;

  assign dl_rise      = ioctl_download & ~dl_q;
  assign dl_fall      = ~ioctl_download & dl_q;
  assign ram_in_range = (ioctl_addr >> RAM_AW) == 25'd0;
  assign rom_in_range = (ioctl_addr >> (ROM_AW + 1)) == 25'd0;
  // Capture only into an empty holder, so capture and issue are mutually exclusive.
  assign capture      = (state == RAM_LOAD) && ioctl_wr && ram_in_range && !hold_valid;
  assign issue        = !cpu_ce && hold_valid;

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dl_rise && ioctl_index == 8'd0)      state_next = ROM_LOAD;
        else if (dl_rise && ioctl_index == 8'd1) state_next = RAM_LOAD;
      end
      RAM_LOAD, ROM_LOAD: if (dl_fall) state_next = FLUSH;
      FLUSH:              if (!hold_valid) state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  // from_rom remembers which load fed FLUSH so cpu_hold survives a ROM flush.
  always_comb begin
    from_rom_next = from_rom;
    if (state == ROM_LOAD)      from_rom_next = 1'b1;
    else if (state == RAM_LOAD) from_rom_next = 1'b0;
    cpu_hold_next  = (state_next == ROM_LOAD) || (state_next == FLUSH && from_rom_next);
    load_done_next = (state == FLUSH) && (state_next == IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q      <= 1'b0;
      from_rom  <= 1'b0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      from_rom  <= from_rom_next;
      cpu_hold  <= cpu_hold_next;
      load_done <= load_done_next;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      ioctl_wait <= 1'b0;
      overrun    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      if (cpu_ce) begin
        ram_we    <= cpu_ram_we;
        ram_addr  <= cpu_ram_addr;
        ram_wdata <= cpu_ram_wdata;
      end else if (hold_valid) begin
        ram_we    <= 1'b1;
        ram_addr  <= hold_addr;
        ram_wdata <= hold_data;
      end else begin
        ram_we    <= 1'b0;
      end
      if (capture) begin
        hold_addr <= ioctl_addr[RAM_AW-1:0];
        hold_data <= ioctl_dout;
      end
      hold_valid <= capture | (hold_valid & ~issue);
      ioctl_wait <= capture | (hold_valid & ~issue);
      if (state == RAM_LOAD && ioctl_wr && hold_valid) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lo_byte   <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
    end else begin
      rom_we <= 1'b0;
      if (state == ROM_LOAD && ioctl_wr && rom_in_range) begin
        if (!ioctl_addr[0]) begin
          lo_byte <= ioctl_dout;
        end else begin
          rom_we    <= 1'b1;
          rom_addr  <= ioctl_addr[ROM_AW:1];
          rom_wdata <= {ioctl_dout, lo_byte};
        end
      end
    end
  end

endmodule

// File: tb/tb_gigatron_load_arbiter.sv
// Directed bench for gigatron_load_arbiter: RAM/ROM writes are scoreboarded,
// control outputs are checked at fixed points in the sequence.
module tb_gigatron_load_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        cpu_ce, cpu_ram_we;
  logic [14:0] cpu_ram_addr;
  logic [7:0]  cpu_ram_wdata;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait, rom_we;
  logic [15:0] rom_addr, rom_wdata;
  logic        cpu_hold, load_done, overrun;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [32:0] sb[$];

  gigatron_load_arbiter #(.RAM_AW(15), .ROM_AW(16)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .cpu_ce(cpu_ce), .cpu_ram_we(cpu_ram_we), .cpu_ram_addr(cpu_ram_addr),
    .cpu_ram_wdata(cpu_ram_wdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ram_ent(input logic [15:0] a, input logic [7:0] d);
    return {1'b0, a, 8'h00, d};
  endfunction

  function automatic logic [32:0] rom_ent(input logic [15:0] a, input logic [15:0] d);
    return {1'b1, a, d};
  endfunction

  // Every write strobe must match the oldest expected entry; a sentinel flags extras.
  always @(negedge clk_sys) begin
    logic [32:0] exp_v;
    if (ram_we) begin
      exp_v = (sb.size() != 0) ? sb.pop_front() : 33'h1FFFFFFFF;
      check("ram_write", 64'({1'b0, 16'(ram_addr), 8'h00, ram_wdata}), 64'(exp_v));
    end
    if (rom_we) begin
      exp_v = (sb.size() != 0) ? sb.pop_front() : 33'h1FFFFFFFF;
      check("rom_write", 64'({1'b1, rom_addr, rom_wdata}), 64'(exp_v));
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_ce = 1'b0; cpu_ram_we = 1'b0; cpu_ram_addr = '0; cpu_ram_wdata = '0;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
    tick(); tick();
    check("reset_flags", 64'({ram_we, ioctl_wait, rom_we, cpu_hold, load_done, overrun}), 64'd0);
    check("reset_ram_port", 64'({ram_addr, ram_wdata}), 64'd0);
    check("reset_rom_port", 64'({rom_addr, rom_wdata}), 64'd0);
    reset = 1'b0;
    tick();

    // RAM load, single byte, no CPU contention
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    sb.push_back(ram_ent(16'h0100, 8'h5A));
    wr(25'h0100, 8'h5A);
    check("ram_wait_high", 64'(ioctl_wait), 64'd1);
    tick();
    check("ram_wait_low", 64'(ioctl_wait), 64'd0);
    check("ram_issue_addr", 64'(ram_addr), 64'h0100);

    // CPU reads at 0x7FFF hold off the loader for three cycles
    cpu_ce = 1'b1; cpu_ram_we = 1'b0; cpu_ram_addr = 15'h7FFF; cpu_ram_wdata = 8'hEE;
    sb.push_back(ram_ent(16'h0200, 8'hC3));
    wr(25'h0200, 8'hC3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("contend_cpu_addr", 64'({ram_we, ram_addr}), 64'({1'b0, 15'h7FFF}));
      check("contend_wait", 64'(ioctl_wait), 64'd1);
    end
    cpu_ce = 1'b0;
    tick();
    check("contend_issue", 64'({ram_we, ram_addr, ram_wdata}), 64'({1'b1, 15'h0200, 8'hC3}));
    check("contend_wait_low", 64'(ioctl_wait), 64'd0);

    // CPU write passes straight through
    cpu_ce = 1'b1; cpu_ram_we = 1'b1; cpu_ram_addr = 15'h1234; cpu_ram_wdata = 8'h77;
    sb.push_back(ram_ent(16'h1234, 8'h77));
    tick();
    cpu_ce = 1'b0; cpu_ram_we = 1'b0;

    // Overrun: second byte while held is dropped, first survives
    cpu_ce = 1'b1;
    sb.push_back(ram_ent(16'h0300, 8'h11));
    wr(25'h0300, 8'h11);
    check("overrun_before", 64'(overrun), 64'd0);
    wr(25'h0301, 8'h22);
    check("overrun_set", 64'(overrun), 64'd1);
    cpu_ce = 1'b0;
    tick();
    tick();
    check("overrun_sticky", 64'(overrun), 64'd1);

    // Out-of-range RAM address
    wr(25'h8000, 8'h99);
    check("bound_no_wait", 64'(ioctl_wait), 64'd0);
    tick();
    check("bound_no_we", 64'(ram_we), 64'd0);

    // Download falls while a write is held behind the CPU
    cpu_ce = 1'b1;
    sb.push_back(ram_ent(16'h0400, 8'h44));
    wr(25'h0400, 8'h44);
    ioctl_download = 1'b0;
    tick();
    check("flush_wait_done0", 64'(load_done), 64'd0);
    tick();
    check("flush_wait_done1", 64'(load_done), 64'd0);
    cpu_ce = 1'b0;
    tick();
    check("flush_issue_done", 64'({ram_we, load_done}), 64'({1'b1, 1'b0}));
    tick();
    check("flush_done_pulse", 64'({load_done, cpu_hold}), 64'({1'b1, 1'b0}));
    tick();
    check("flush_done_end", 64'(load_done), 64'd0);

    // ROM load with word packing
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick();
    check("rom_hold_entry", 64'(cpu_hold), 64'd1);
    wr(25'h0, 8'h00);
    check("rom_even_no_we", 64'(rom_we), 64'd0);
    sb.push_back(rom_ent(16'h0000, 16'h1800));
    wr(25'h1, 8'h18);
    check("rom_word0", 64'({rom_we, rom_addr, rom_wdata}), 64'({1'b1, 16'h0000, 16'h1800}));
    wr(25'h2, 8'hCD);
    sb.push_back(rom_ent(16'h0001, 16'hABCD));
    wr(25'h3, 8'hAB);
    sb.push_back(rom_ent(16'h0002, 16'h77CD));
    wr(25'h5, 8'h77);
    wr(25'h20001, 8'hEE);
    check("rom_bound_no_we", 64'(rom_we), 64'd0);
    check("rom_hold_wait", 64'({cpu_hold, ioctl_wait}), 64'({1'b1, 1'b0}));
    ioctl_download = 1'b0;
    tick();
    check("rom_flush_hold", 64'({cpu_hold, load_done}), 64'({1'b1, 1'b0}));
    tick();
    check("rom_done_pulse", 64'({cpu_hold, load_done}), 64'({1'b0, 1'b1}));
    tick();
    check("rom_done_end", 64'(load_done), 64'd0);

    // Unknown index is ignored entirely
    ioctl_index = 8'd5; ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      wr(25'(i), 8'(8'hA0 + i));
      check("unk_idle", 64'({cpu_hold, ioctl_wait}), 64'd0);
    end
    ioctl_download = 1'b0;
    tick();
    check("unk_no_done0", 64'(load_done), 64'd0);
    tick();
    check("unk_no_done1", 64'(load_done), 64'd0);

    // Reset with a held write discards it
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    cpu_ce = 1'b1;
    wr(25'h0500, 8'h55);
    check("rst_held_wait", 64'(ioctl_wait), 64'd1);
    reset = 1'b1; cpu_ce = 1'b0; ioctl_download = 1'b0;
    tick();
    check("rst_flags", 64'({ram_we, ioctl_wait, rom_we, cpu_hold, load_done, overrun}), 64'd0);
    check("rst_ports", 64'({ram_addr, ram_wdata, rom_addr, rom_wdata}), 64'd0);
    reset = 1'b0;
    tick();
    check("rst_no_we0", 64'(ram_we), 64'd0);
    tick();
    check("rst_no_we1", 64'(ram_we), 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
